// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Holds the program counter and sequences instruction fetch. The current PC
//   goes to an external adder (a = pc, b = 4). The adder's result returns as
//   seq_pc. Word fetches are issued over a req/ready handshake. One fetched
//   instruction is buffered for decode. Branch/jump redirects from later
//   stages take priority over every other event.
//
// Ports
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   pc              : current PC register, operand a of the sequential adder
//   seq_pc          : adder result (pc + 4), next sequential PC
//   redirect        : single-cycle branch/jump taken pulse
//   redirect_pc     : redirect target (low two bits forced to zero on use)
//   imem_req        : fetch request valid
//   imem_addr       : fetch address (equals pc while imem_req = 1)
//   imem_ready      : memory presents imem_rdata this cycle
//   imem_rdata      : instruction word from memory
//   inst_valid      : instruction buffer valid towards decode
//   inst, inst_pc   : buffered instruction and its PC
//   inst_ready      : decode accepts the buffered instruction
//   err_misalign    : one-cycle pulse after a misaligned redirect target
//   fetch_count     : number of instructions accepted by decode (wraps)
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  input  logic [31:0] seq_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        err_misalign,
  output logic [31:0] fetch_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] VALID = 2'd2;

  logic [1:0]  state;
  logic        pend;
  logic [31:0] pend_pc;
  logic [31:0] target;
  logic        target_misaligned;

  // Forces a target onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  assign target            = align_word(redirect_pc);
  assign target_misaligned = (redirect_pc[1:0] != 2'b00);

  // The request and the buffer-valid signals decode directly from the state
  // register. A redirect kills the buffered instruction in the same cycle.
  // Because of this, decode never sees a transfer that the redirect has
  // already squashed.
  assign imem_req   = (state == REQ);
  assign imem_addr  = pc;
  assign inst_valid = (state == VALID) && !redirect;

  // Fetch FSM, PC update, pending-redirect capture, instruction buffer and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      pend         <= 1'b0;
      pend_pc      <= 32'h0000_0000;
      inst         <= 32'h0000_0000;
      inst_pc      <= 32'h0000_0000;
      err_misalign <= 1'b0;
      fetch_count  <= 32'h0000_0000;
    end else begin
      err_misalign <= 1'b0;
      case (state)
        IDLE: begin
          state <= REQ;
        end
        REQ: begin
          if (imem_ready) begin
            if (redirect) begin
              // Returning data belongs to the old path; restart at the new target.
              pc           <= target;
              pend         <= 1'b0;
              err_misalign <= target_misaligned;
            end else if (pend) begin
              pc   <= pend_pc;
              pend <= 1'b0;
            end else begin
              inst    <= imem_rdata;
              inst_pc <= pc;
              state   <= VALID;
            end
          end else if (redirect) begin
            // The address must stay stable while a request is outstanding.
            // Park the target until the memory answers. The latest target wins.
            pend         <= 1'b1;
            pend_pc      <= target;
            err_misalign <= target_misaligned;
          end
        end
        VALID: begin
          if (redirect) begin
            pc           <= target;
            state        <= REQ;
            err_misalign <= target_misaligned;
          end else if (inst_ready) begin
            fetch_count <= fetch_count + 32'd1;
            pc          <= seq_pc;
            state       <= REQ;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] seq_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        err_misalign;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // External sequential adder and a memory whose word is a fixed function of its address.
  assign seq_pc     = pc + 32'd4;
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  pc_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst(rst), .pc(pc), .seq_pc(seq_pc),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .err_misalign(err_misalign),
    .fetch_count(fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ready = 1'b1; inst_ready = 1'b1;
    step(); step();
    check("rst_pc",    pc,                 32'h0000_3000);
    check("rst_req",   {31'd0, imem_req},  32'd0);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst",  inst,               32'd0);
    check("rst_ipc",   inst_pc,            32'd0);
    check("rst_cnt",   fetch_count,        32'd0);
    check("rst_err",   {31'd0, err_misalign}, 32'd0);
    rst = 1'b0;

    // Zero-wait streaming: REQ -> VALID -> REQ per instruction.
    step();
    for (int k = 0; k < 3; k++) begin
      check("seq_req",  {31'd0, imem_req}, 32'd1);
      check("seq_addr", imem_addr, 32'h0000_3000 + 32'(4 * k));
      check("seq_cnt",  fetch_count, 32'(k));
      step();
      check("seq_valid", {31'd0, inst_valid}, 32'd1);
      check("seq_ipc",   inst_pc, 32'h0000_3000 + 32'(4 * k));
      check("seq_inst",  inst, (32'h0000_3000 + 32'(4 * k)) ^ 32'hA5A5_0000);
      step();
    end
    check("seq_cnt3", fetch_count, 32'd3);
    check("seq_pc3",  pc, 32'h0000_300C);

    // Decode stall for five cycles.
    inst_ready = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", {31'd0, inst_valid}, 32'd1);
      check("stall_req",   {31'd0, imem_req}, 32'd0);
      check("stall_ipc",   inst_pc, 32'h0000_300C);
      check("stall_inst",  inst, 32'h0000_300C ^ 32'hA5A5_0000);
      check("stall_pc",    pc, 32'h0000_300C);
      step();
    end
    inst_ready = 1'b1;
    step();
    check("release_pc",  pc, 32'h0000_3010);
    check("release_cnt", fetch_count, 32'd4);

    // Two redirects while the fetch of 0x3010 is outstanding.
    imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_4000;
    #1;
    check("pend1_addr",  imem_addr, 32'h0000_3010);
    check("pend1_valid", {31'd0, inst_valid}, 32'd0);
    step();
    redirect_pc = 32'h0000_5000;
    #1;
    check("pend2_addr",  imem_addr, 32'h0000_3010);
    check("pend2_pc",    pc, 32'h0000_3010);
    check("pend2_valid", {31'd0, inst_valid}, 32'd0);
    step();
    redirect = 1'b0; imem_ready = 1'b1;
    #1;
    check("pend3_addr",  imem_addr, 32'h0000_3010);
    check("pend3_valid", {31'd0, inst_valid}, 32'd0);
    step();
    check("pend_req",   {31'd0, imem_req}, 32'd1);
    check("pend_addr",  imem_addr, 32'h0000_5000);
    check("pend_valid", {31'd0, inst_valid}, 32'd0);
    check("pend_err",   {31'd0, err_misalign}, 32'd0);
    step();
    check("pend_ipc", inst_pc, 32'h0000_5000);
    check("pend_v2",  {31'd0, inst_valid}, 32'd1);
    check("pend_cnt", fetch_count, 32'd4);

    // Redirect collides with inst_ready in VALID; the target is misaligned.
    redirect = 1'b1; redirect_pc = 32'h0000_3101;
    #1;
    check("coll_valid", {31'd0, inst_valid}, 32'd0);
    step();
    redirect = 1'b0;
    check("coll_cnt",  fetch_count, 32'd4);
    check("coll_addr", imem_addr, 32'h0000_3100);
    check("coll_err",  {31'd0, err_misalign}, 32'd1);
    step();
    check("coll_err_off", {31'd0, err_misalign}, 32'd0);
    check("coll_ipc",     inst_pc, 32'h0000_3100);
    step();
    check("coll_cnt5", fetch_count, 32'd5);
    check("coll_req",  {31'd0, imem_req}, 32'd1);

    // Asynchronous reset while a request is active, away from a clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("arst_req",   {31'd0, imem_req}, 32'd0);
    check("arst_valid", {31'd0, inst_valid}, 32'd0);
    check("arst_pc",    pc, 32'h0000_3000);
    check("arst_cnt",   fetch_count, 32'd0);
    step();
    rst = 1'b0;
    step();
    check("arst_addr", imem_addr, 32'h0000_3000);

    // Wraparound of the PC through the sequential adder.
    step();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    check("wrap_err",   {31'd0, err_misalign}, 32'd0);
    step();
    check("wrap_ipc", inst_pc, 32'hFFFF_FFFC);
    step();
    check("wrap_addr", imem_addr, 32'h0000_0000);
    check("wrap_cnt",  fetch_count, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
